// File: rtl/libhdl_fifo_cc_pkt.sv
// libhdl_fifo_cc_pkt: single-clock FIFO with packet commit/abort, overflow drop and a registered FWFT output stage
module libhdl_fifo_cc_pkt #(
    parameter int DATA_LEN = 32,
    parameter int DEPTH = 16,
    parameter int PKT_MODE = 1,
    parameter int ALMOST_EMPTY_CNT = DEPTH / 4,
    parameter int ALMOST_FULL_CNT = DEPTH - DEPTH / 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_wrdy,
    input  logic                i_wvld,
    input  logic [DATA_LEN-1:0] i_wdat,
    input  logic                i_wlast,
    input  logic                i_wabort,
    input  logic                i_rrdy,
    output logic                o_rvld,
    output logic [DATA_LEN-1:0] o_rdat,
    output logic                o_rlast,
    output logic [CW-1:0]       o_count,
    output logic [CW-1:0]       o_pkt_count,
    output logic                o_empty,
    output logic                o_full,
    output logic                o_almost_empty,
    output logic                o_almost_full,
    output logic                o_drop
);
    localparam int AW = CW - 1;
    typedef enum logic {PASS, DROP} state_t;
    state_t state;
    logic [CW-1:0] wr_ptr, wc_ptr, rd_ptr, used, rd_nxt;
    logic [DATA_LEN:0] mem [DEPTH];
    logic wr_xfer, rd_xfer, abort, store, commit, drop_go, load, avail;
    assign used = wr_ptr - rd_ptr;
    assign o_count = wc_ptr - rd_ptr;
    assign o_full = used == CW'(DEPTH);
    assign o_wrdy = !o_full || state == DROP;
    assign o_empty = o_count == '0;
    assign o_almost_empty = o_count <= CW'(ALMOST_EMPTY_CNT);
    assign o_almost_full = used >= CW'(ALMOST_FULL_CNT);
    assign wr_xfer = i_wvld && o_wrdy;
    assign rd_xfer = o_rvld && i_rrdy;
    assign abort = PKT_MODE != 0 && i_wabort;
    assign store = wr_xfer && state == PASS && !abort;
    assign commit = store && (PKT_MODE == 0 || i_wlast);
    // storage holds only an open packet: abandon it so the writer is never stalled forever
    assign drop_go = PKT_MODE != 0 && state == PASS && o_full && o_empty && !abort;
    assign rd_nxt = rd_ptr + CW'(rd_xfer);
    assign load = !o_rvld || i_rrdy;
    assign avail = wc_ptr != rd_nxt;
    always_ff @(posedge i_clk) begin
        if (store)
            mem[wr_ptr[AW-1:0]] <= {i_wlast, i_wdat};
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            wc_ptr <= '0;
            rd_ptr <= '0;
            state <= PASS;
            o_pkt_count <= '0;
            o_rvld <= 1'b0;
            o_rdat <= '0;
            o_rlast <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            if (drop_go || abort)
                wr_ptr <= wc_ptr;
            else if (store)
                wr_ptr <= wr_ptr + 1'b1;
            if (commit)
                wc_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_nxt;
            o_drop <= drop_go;
            state <= state == PASS ? (drop_go ? DROP : PASS) :
                     (abort || (wr_xfer && i_wlast)) ? PASS : DROP;
            o_pkt_count <= o_pkt_count + CW'(commit && i_wlast) - CW'(rd_xfer && o_rlast);
            // output register refills from the word after any read taking place now
            if (load) begin
                o_rvld <= avail;
                if (avail)
                    {o_rlast, o_rdat} <= mem[rd_nxt[AW-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_libhdl_fifo_cc_pkt.sv
// tb_libhdl_fifo_cc_pkt: packet-mode and word-mode instances checked each cycle against a queue-level model
module tb_libhdl_fifo_cc_pkt;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic wvld [2], wlast [2], wabort [2], rrdy [2];
    logic [31:0] wdat [2], rdat [2];
    logic wrdy [2], rvld [2], rlast [2], empty [2], full [2], ae [2], af [2], drop [2];
    logic [4:0] count [2], pkt [2];
    libhdl_fifo_cc_pkt #(.PKT_MODE(1)) u0 (
        .i_clk(clk), .i_rst(rst), .o_wrdy(wrdy[0]), .i_wvld(wvld[0]), .i_wdat(wdat[0]),
        .i_wlast(wlast[0]), .i_wabort(wabort[0]), .i_rrdy(rrdy[0]), .o_rvld(rvld[0]),
        .o_rdat(rdat[0]), .o_rlast(rlast[0]), .o_count(count[0]), .o_pkt_count(pkt[0]),
        .o_empty(empty[0]), .o_full(full[0]), .o_almost_empty(ae[0]),
        .o_almost_full(af[0]), .o_drop(drop[0]));
    libhdl_fifo_cc_pkt #(.PKT_MODE(0)) u1 (
        .i_clk(clk), .i_rst(rst), .o_wrdy(wrdy[1]), .i_wvld(wvld[1]), .i_wdat(wdat[1]),
        .i_wlast(wlast[1]), .i_wabort(wabort[1]), .i_rrdy(rrdy[1]), .o_rvld(rvld[1]),
        .o_rdat(rdat[1]), .o_rlast(rlast[1]), .o_count(count[1]), .o_pkt_count(pkt[1]),
        .o_empty(empty[1]), .o_full(full[1]), .o_almost_empty(ae[1]),
        .o_almost_full(af[1]), .o_drop(drop[1]));
    int tests = 0, fails = 0;
    // model: words [head, ctl) are committed and unread, [ctl, ptl) are the open packet
    logic [32:0] mm [2][1024];
    int head [2], ctl [2], ptl [2], ndrop [2];
    bit dst [2], ervld [2], edrop [2], acc [2];
    task automatic chk(string tag, int m, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h", tag, m, act, exp);
        end
    endtask
    task automatic cycle();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            int c, u, pc;
            bit fl, rdy, rd, nr;
            c = ctl[m] - head[m];
            u = ptl[m] - head[m];
            fl = u == 16;
            rdy = !fl || dst[m];
            pc = 0;
            for (int i = head[m]; i < ctl[m]; i++) pc += int'(mm[m][i % 1024][32]);
            chk("wrdy", m, wrdy[m], rdy);
            chk("count", m, count[m], c);
            chk("pkt_count", m, pkt[m], pc);
            chk("empty", m, empty[m], c == 0);
            chk("full", m, full[m], fl);
            chk("almost_empty", m, ae[m], c <= 4);
            chk("almost_full", m, af[m], u >= 12);
            chk("rvld", m, rvld[m], ervld[m]);
            chk("drop", m, drop[m], edrop[m]);
            if (drop[m]) ndrop[m]++;
            if (ervld[m]) begin
                chk("rdat", m, rdat[m], mm[m][head[m] % 1024][31:0]);
                chk("rlast", m, rlast[m], mm[m][head[m] % 1024][32]);
            end
            acc[m] = 0;
            if (rst) begin
                head[m] = 0; ctl[m] = 0; ptl[m] = 0;
                dst[m] = 0; ervld[m] = 0; edrop[m] = 0;
            end else begin
                rd = ervld[m] && rrdy[m];
                acc[m] = wvld[m] && rdy;
                nr = (c - int'(rd)) > 0;
                if (rd) head[m]++;
                edrop[m] = 0;
                if (m == 0 && wabort[m]) begin
                    ptl[m] = ctl[m];
                    dst[m] = 0;
                end else if (m == 0 && !dst[m] && fl && c == 0) begin
                    ptl[m] = ctl[m];
                    dst[m] = 1;
                    edrop[m] = 1;
                end else if (dst[m]) begin
                    if (acc[m] && wlast[m]) dst[m] = 0;
                end else if (acc[m]) begin
                    mm[m][ptl[m] % 1024] = {wlast[m], wdat[m]};
                    ptl[m]++;
                    if (m == 1 || wlast[m]) ctl[m] = ptl[m];
                end
                ervld[m] = nr;
            end
        end
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        for (int m = 0; m < 2; m++) begin
            wvld[m] = 0; wlast[m] = 0; wabort[m] = 0; rrdy[m] = 0; wdat[m] = '0;
        end
    endtask
    task automatic send(int m, logic [31:0] d, bit l);
        wvld[m] = 1; wdat[m] = d; wlast[m] = l;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (acc[m]) break;
        end
        if (!acc[m]) chk("send_timeout", m, 0, 1);
        wvld[m] = 0; wlast[m] = 0;
    endtask
    initial begin
        int d0;
        idle();
        rst = 1;
        repeat (2) cycle();
        rst = 0;
        for (int m = 0; m < 2; m++) begin
            chk("rst_rdat", m, rdat[m], 0);
            chk("rst_rlast", m, rlast[m], 0);
        end
        rrdy[0] = 1;
        for (int i = 0; i < 3; i++) send(0, 32'hA1 + i, i == 2);
        repeat (6) cycle();
        rrdy[0] = 0;
        send(0, 32'h11, 0);
        send(0, 32'h12, 1);
        for (int i = 0; i < 4; i++) send(0, 32'h20 + i, 0);
        wabort[0] = 1;
        cycle();
        wabort[0] = 0;
        cycle();
        chk("abort_count", 0, count[0], 2);
        chk("abort_pkt", 0, pkt[0], 1);
        rrdy[0] = 1;
        repeat (6) cycle();
        rrdy[0] = 0;
        d0 = ndrop[0];
        for (int i = 1; i <= 20; i++) send(0, i, i == 20);
        cycle();
        chk("drop_once", 0, ndrop[0] - d0, 1);
        chk("drop_empty", 0, empty[0], 1);
        chk("drop_wrdy", 0, wrdy[0], 1);
        for (int i = 0; i < 40; i++) begin
            wvld[1] = 1; wdat[1] = $urandom; wlast[1] = $urandom_range(0, 1);
            for (int k = 0; k < 50; k++) begin
                rrdy[1] = $urandom_range(0, 1);
                cycle();
                if (acc[1]) break;
            end
            if (!acc[1]) chk("wr_timeout", 1, 0, 1);
        end
        wvld[1] = 0; rrdy[1] = 1;
        repeat (20) cycle();
        rrdy[1] = 0;
        for (int i = 0; i < 16; i++) send(1, $urandom, 0);
        chk("full16", 1, full[1], 1);
        wvld[1] = 1; rrdy[1] = 1;
        for (int i = 0; i < 10; i++) begin
            wdat[1] = $urandom;
            cycle();
            chk("sim_min15", 1, count[1] >= 15, 1);
        end
        wvld[1] = 0;
        repeat (20) cycle();
        rrdy[0] = 0;
        for (int i = 0; i < 3; i++) send(0, 32'h30 + i, i == 2);
        send(0, 32'h40, 0);
        send(0, 32'h41, 0);
        rst = 1;
        cycle();
        rst = 0;
        chk("mid_rst_count", 0, count[0], 0);
        chk("mid_rst_rvld", 0, rvld[0], 0);
        send(0, 32'h55, 1);
        rrdy[0] = 1;
        repeat (4) cycle();
        for (int k = 0; k < 1500; k++) begin
            for (int m = 0; m < 2; m++) begin
                wvld[m] = $urandom_range(0, 1);
                wdat[m] = $urandom;
                wlast[m] = $urandom_range(0, 3) == 0;
                wabort[m] = $urandom_range(0, 39) == 0;
                rrdy[m] = $urandom_range(0, 3) < (((k / 150) % 2) != 0 ? 1 : 3);
            end
            cycle();
        end
        idle();
        rrdy[0] = 1; rrdy[1] = 1;
        repeat (40) cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
